fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the decode control unit.
- Generates word addresses to instruction memory over a single-outstanding request/valid handshake and registers returned instructions into the IF/ID output register.
- Presents the 5-bit opcode (instr[31:27]) to decode.
- Handles downstream stall with a one-entry skid buffer, branch/jump/call/return redirect with squash of in-flight fetches, and stops fetching after halt (opcode 5'b11111).

Parameters:
PC_W, 32, width of PC / instruction memory word address
INSTR_W, 32, instruction width; opcode is instr[INSTR_W-1:INSTR_W-5]
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  decode cannot accept; hold IF/ID outputs
redirect  in  1  taken branch/jump/call/return/returni from later stage
redirect_pc  in  PC_W  new fetch address, valid with redirect
imem_req  out  1  one-cycle request pulse; memory samples imem_addr
imem_addr  out  PC_W  word address of request
imem_valid  in  1  response for the single outstanding request, >=1 cycle after imem_req
imem_rdata  in  INSTR_W  instruction data, valid with imem_valid
if_valid  out  1  IF/ID register holds a real instruction
if_instr  out  INSTR_W  fetched instruction; 0 (nop) when if_valid=0
if_opcode  out  5  if_instr[INSTR_W-1:INSTR_W-5], feeds control unit
if_pc  out  PC_W  address of if_instr
if_pc_plus1  out  PC_W  if_pc+1, return address for call
halted  out  1  halt instruction delivered, fetch stopped

Behaviour:
- Reset (async, rst_n=0): state=ISSUE, fetch_pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus1=0, halted=0, skid empty, imem_req=0 while in reset.
- The first request is issued in the first cycle after rst_n rises.
- States:
  - ISSUE: imem_req=1, imem_addr=fetch_pc; next WAIT.
  - WAIT: await imem_valid.
  - SKID: a response is buffered; no request outstanding.
  - DROP: in-flight response is to be discarded.
  - HALT: no requests.
- WAIT, imem_valid=1, stall=0, no redirect:
  - IF/ID loads rdata, if_pc=fetch_pc, if_valid=1 next cycle (1-cycle latency).
  - If the opcode is not 11111: chained issue in the same cycle, with imem_req=1, imem_addr=fetch_pc+1, fetch_pc<=fetch_pc+1; stay WAIT. This gives 1 instr/cycle with 1-cycle memory.
  - If the opcode is 11111: go HALT, halted=1 from the next cycle, no further imem_req.
- WAIT, imem_valid=1, stall=1: rdata and fetch_pc go into the skid buffer; next SKID; imem_req=0.
- SKID, stall=0: skid moves to IF/ID, fetch_pc<=fetch_pc+1, next ISSUE. If the skid instruction is a halt, go HALT instead.
- IF/ID hold rule: while stall=1 all if_* outputs hold their value.
- Bubble rule: with stall=0 and no new instruction, if_valid<=0 and if_instr<=0.
- redirect=1 has highest priority in every state and overrides stall:
  - IF/ID flushed (if_valid<=0, if_instr<=0); skid cleared; halted<=0; fetch_pc<=redirect_pc.
  - From ISSUE, or WAIT with imem_valid=0: go DROP.
  - From WAIT with imem_valid=1 in the same cycle: the response is discarded; go ISSUE.
  - From SKID or HALT: go ISSUE.
- DROP: imem_req=0; on imem_valid discard data, go ISSUE. A redirect in DROP only updates fetch_pc.
- fetch_pc arithmetic wraps modulo 2^PC_W (all-ones + 1 = 0).
- Never more than one outstanding request. imem_req is never asserted in DROP, SKID or HALT.
- A reset mid-operation abandons any outstanding request. The memory must also be reset by rst_n.

Test Plan:
1. Reset, RESET_PC=0, 1-cycle memory returning instr=addr<<27 (non-halt opcodes), stall=0 -> imem_addr 0,1,2,3 on consecutive cycles; if_pc 0,1,2 with if_valid=1 every cycle from cycle 3; if_pc_plus1=if_pc+1.
2. stall=1 for 3 cycles while the response for addr 5 arrives -> IF/ID holds the addr 4 instruction; skid holds 5; imem_req=0. When stall drops, if_pc=5, then ISSUE at addr 6.
3. redirect=1, redirect_pc=0x40 while the request for addr 7 is outstanding with 3-cycle latency -> if_valid=0 next cycle; the addr 7 response is discarded; next imem_addr=0x40; no instruction at pc 7 ever reaches if_valid=1.
4. Fetch instr with opcode 5'b11111 at addr 9 -> if_opcode=5'b11111 at if_pc=9; halted=1; imem_req stays 0 for 20 cycles. Then redirect_pc=0x10 -> halted=0, imem_addr=0x10.
5. redirect and stall both 1 in the same cycle with if_valid=1 -> if_valid=0 next cycle (flush wins).
6. RESET_PC=32'hFFFF_FFFF -> first imem_addr FFFF_FFFF, second 0. Assert rst_n=0 mid-WAIT -> outputs are at reset values immediately (asynchronously); first request after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding request/valid fetch from
// instruction memory into the IF/ID register, with a one-entry skid buffer
// for decode stalls, redirect/squash handling and halt detection.
//
// Memory handshake: imem_req is a one-cycle pulse, and the memory captures
// imem_addr on the rising edge where imem_req=1. Exactly one imem_valid
// pulse (carrying imem_rdata) answers each request, at least one cycle
// later. A new request is only issued once the previous one has been
// answered; the answer cycle itself may carry the next request.
// Decode side: if_valid qualifies if_instr/if_pc; stall=1 freezes every
// if_* output for that cycle.
module fetch_unit #(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [4:0]         if_opcode,
    output logic [PC_W-1:0]    if_pc,
    output logic [PC_W-1:0]    if_pc_plus1,
    output logic               halted,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_ISSUE = 3'd0,
        S_WAIT  = 3'd1,
        S_SKID  = 3'd2,
        S_DROP  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [4:0]      HALT_OPC   = 5'b11111;

    state_t               r_state;
    state_t               w_next_state;
    logic [PC_W-1:0]      r_fetch_pc;
    logic [PC_W-1:0]      w_next_pc;
    logic [PC_W-1:0]      w_pc_inc;
    logic [INSTR_W-1:0]   r_skid_instr;
    logic                 r_if_valid;
    logic [INSTR_W-1:0]   r_if_instr;
    logic [PC_W-1:0]      r_if_pc;
    logic [PC_W-1:0]      r_if_pc_plus1;
    logic                 r_halted;

    logic                 w_req;
    logic [PC_W-1:0]      w_addr;
    logic                 w_flush;
    logic                 w_load_mem;
    logic                 w_load_skid;
    logic                 w_skid_capture;
    logic                 w_set_halt;
    logic                 w_rdata_is_halt;
    logic                 w_skid_is_halt;

    assign w_pc_inc        = r_fetch_pc + PC_ONE;
    assign w_rdata_is_halt = (imem_rdata[INSTR_W-1:INSTR_W-5] == HALT_OPC);
    assign w_skid_is_halt  = (r_skid_instr[INSTR_W-1:INSTR_W-5] == HALT_OPC);

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_ISSUE;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_pc;
        end
    end

    // Next-state, request generation and IF/ID load controls; redirect wins over everything.
    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_fetch_pc;
        w_req          = 1'b0;
        w_addr         = r_fetch_pc;
        w_flush        = 1'b0;
        w_load_mem     = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_capture = 1'b0;
        w_set_halt     = 1'b0;
        case (r_state)
            S_ISSUE: begin
                // The request still goes out; its answer is dropped on redirect.
                w_req = 1'b1;
                if (redirect) begin
                    w_flush      = 1'b1;
                    w_next_pc    = redirect_pc;
                    w_next_state = S_DROP;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_flush      = 1'b1;
                    w_next_pc    = redirect_pc;
                    w_next_state = imem_valid ? S_ISSUE : S_DROP;
                end else if (imem_valid) begin
                    if (stall) begin
                        w_skid_capture = 1'b1;
                        w_next_state   = S_SKID;
                    end else begin
                        w_load_mem = 1'b1;
                        if (w_rdata_is_halt) begin
                            w_set_halt   = 1'b1;
                            w_next_state = S_HALT;
                        end else begin
                            // Chain the next fetch in the answer cycle for 1 instr/cycle.
                            w_req     = 1'b1;
                            w_addr    = w_pc_inc;
                            w_next_pc = w_pc_inc;
                        end
                    end
                end
            end
            S_SKID: begin
                if (redirect) begin
                    w_flush      = 1'b1;
                    w_next_pc    = redirect_pc;
                    w_next_state = S_ISSUE;
                end else if (!stall) begin
                    w_load_skid = 1'b1;
                    if (w_skid_is_halt) begin
                        w_set_halt   = 1'b1;
                        w_next_state = S_HALT;
                    end else begin
                        w_next_pc    = w_pc_inc;
                        w_next_state = S_ISSUE;
                    end
                end
            end
            S_DROP: begin
                // Still owed one response; only the target address may change.
                if (redirect) begin
                    w_flush   = 1'b1;
                    w_next_pc = redirect_pc;
                end
                if (imem_valid) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_HALT: begin
                if (redirect) begin
                    w_flush      = 1'b1;
                    w_next_pc    = redirect_pc;
                    w_next_state = S_ISSUE;
                end
            end
            default: begin
                w_next_state = S_ISSUE;
            end
        endcase
    end

    // Skid buffer captures a response that arrived while decode was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_instr <= '0;
        end else if (w_flush) begin
            r_skid_instr <= '0;
        end else if (w_skid_capture) begin
            r_skid_instr <= imem_rdata;
        end
    end

    // IF/ID register: flush, load from memory or skid, hold on stall, else bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_pc_plus1 <= '0;
        end else if (w_flush) begin
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
        end else if (w_load_mem) begin
            r_if_valid    <= 1'b1;
            r_if_instr    <= imem_rdata;
            r_if_pc       <= r_fetch_pc;
            r_if_pc_plus1 <= w_pc_inc;
        end else if (w_load_skid) begin
            r_if_valid    <= 1'b1;
            r_if_instr    <= r_skid_instr;
            r_if_pc       <= r_fetch_pc;
            r_if_pc_plus1 <= w_pc_inc;
        end else if (!stall) begin
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
        end
    end

    // Halt flag: set when a halt reaches IF/ID, cleared by any redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (w_flush) begin
            r_halted <= 1'b0;
        end else if (w_set_halt) begin
            r_halted <= 1'b1;
        end
    end

    // No request may be seen by the memory while reset is held.
    assign imem_req    = w_req & rst_n;
    assign imem_addr   = w_addr;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_opcode   = r_if_instr[INSTR_W-1:INSTR_W-5];
    assign if_pc       = r_if_pc;
    assign if_pc_plus1 = r_if_pc_plus1;
    assign halted      = r_halted;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model, a stream-level
// reference model checked every cycle, and a directed cycle script with
// hand-computed expectations.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] HALT_ADDR = 32'd9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [4:0]  if_opcode;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus1;
    logic        halted;
    logic [2:0]  dbg_state;

    // second instance for the wrap-around reset address
    logic        h_rst_n;
    logic        h_stall;
    logic        h_redirect;
    logic [31:0] h_redirect_pc;
    logic        h_req;
    logic [31:0] h_addr;
    logic        h_valid;
    logic [31:0] h_rdata;
    logic        h_if_valid;
    logic [31:0] h_if_instr;
    logic [4:0]  h_if_opcode;
    logic [31:0] h_if_pc;
    logic [31:0] h_if_pc_plus1;
    logic        h_halted;
    logic [2:0]  h_dbg_state;

    fetch_unit #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_opcode(if_opcode), .if_pc(if_pc),
        .if_pc_plus1(if_pc_plus1), .halted(halted), .dbg_state(dbg_state)
    );

    fetch_unit #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFF)) u_dut_hi (
        .clk(clk), .rst_n(h_rst_n), .stall(h_stall), .redirect(h_redirect),
        .redirect_pc(h_redirect_pc), .imem_req(h_req), .imem_addr(h_addr),
        .imem_valid(h_valid), .imem_rdata(h_rdata), .if_valid(h_if_valid),
        .if_instr(h_if_instr), .if_opcode(h_if_opcode), .if_pc(h_if_pc),
        .if_pc_plus1(h_if_pc_plus1), .halted(h_halted), .dbg_state(h_dbg_state)
    );

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image: opcode is 11111 only at HALT_ADDR, low bits echo the address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [4:0] opc;
        opc = (addr == HALT_ADDR) ? 5'h1F : {1'b0, addr[3:0]};
        return {opc, 3'b101, addr[23:0]};
    endfunction

    // ---------------- memory models ----------------
    int          mem_lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr_q = '0;

    initial begin
        imem_valid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_valid = 1'b0;
            imem_rdata = '0;
            if (!rst_n) begin
                mem_busy = 1'b0;
            end else if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(mem_addr_q);
                    mem_busy   = 1'b0;
                end
            end
            #3;
            if (rst_n && imem_req) begin
                mem_busy   = 1'b1;
                mem_cnt    = mem_lat;
                mem_addr_q = imem_addr;
            end
        end
    end

    logic        h_pend = 1'b0;
    logic [31:0] h_paddr = '0;

    initial begin
        h_valid = 1'b0;
        h_rdata = '0;
        forever begin
            @(negedge clk);
            h_valid = h_pend && h_rst_n;
            h_rdata = mem_word(h_paddr);
            #3;
            h_pend  = h_rst_n && h_req;
            h_paddr = h_addr;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic [31:0] m_issue;
    logic [31:0] m_deliv;
    int          m_out;
    logic        m_halt;
    logic        p_live = 1'b0;
    logic        p_stall, p_redir, p_req, p_valid_in;
    logic [31:0] p_rpc, p_addr;
    logic [96:0] p_ifid;

    initial forever begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
            check("reset_outputs", {if_valid, if_instr, if_pc, if_pc_plus1, halted, imem_req}, '0);
            m_issue = 32'h0;
            m_deliv = 32'h0;
            m_out   = 0;
            m_halt  = 1'b0;
            p_live  = 1'b0;
        end else begin
            if (p_live) begin
                if (p_req) m_issue = p_addr + 32'd1;
                m_out = m_out + (p_req ? 1 : 0) - (p_valid_in ? 1 : 0);
                if (p_redir) begin
                    m_issue = p_rpc;
                    m_deliv = p_rpc;
                    m_halt  = 1'b0;
                    check("flush_valid", if_valid, 1'b0);
                end else if (p_stall) begin
                    check("stall_hold", {if_valid, if_instr, if_pc, if_pc_plus1}, p_ifid);
                end
            end
            check("outstanding_le1", (m_out <= 1), 1'b1);
            if (imem_req) begin
                check("req_addr", imem_addr, m_issue);
                check("req_single", (m_out == (imem_valid ? 1 : 0)), 1'b1);
                check("req_after_halt", m_halt, 1'b0);
            end
            if (!if_valid) check("bubble_nop", if_instr, 32'h0);
            if (if_valid && p_live && !p_stall && !p_redir) begin
                check("deliv_pc", if_pc, m_deliv);
                check("deliv_instr", if_instr, mem_word(if_pc));
                check("deliv_pc_plus1", if_pc_plus1, if_pc + 32'd1);
                check("deliv_opcode", if_opcode, if_instr[31:27]);
                m_deliv = m_deliv + 32'd1;
                if (if_instr[31:27] == 5'h1F) m_halt = 1'b1;
            end
            check("halted_flag", halted, m_halt);
            p_live = 1'b1;
        end
        p_stall    = stall;
        p_redir    = redirect;
        p_rpc      = redirect_pc;
        p_req      = imem_req;
        p_addr     = imem_addr;
        p_valid_in = imem_valid;
        p_ifid     = {if_valid, if_instr, if_pc, if_pc_plus1};
    end

    // ---------------- directed script ----------------
    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        h_rst_n       = 1'b0;
        h_stall       = 1'b0;
        h_redirect    = 1'b0;
        h_redirect_pc = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 56; c++) begin
            if (c > 0) @(negedge clk);
            stall    = (c >= 6 && c <= 8) || (c == 45);
            redirect = (c == 12) || (c == 18) || (c == 42) || (c == 45);
            case (c)
                12:      redirect_pc = 32'h40;
                18:      redirect_pc = 32'h8;
                42:      redirect_pc = 32'h10;
                45:      redirect_pc = 32'h20;
                default: redirect_pc = 32'h0;
            endcase
            if (c == 11) mem_lat = 3;
            if (c == 15) mem_lat = 1;
            if (c == 48) mem_lat = 3;
            if (c == 50) mem_lat = 1;
            if (c == 53) rst_n = 1'b1;
            if (c == 49) begin
                #1;
                check("pre_reset_if", {if_valid, if_pc}, {1'b1, 32'h21});
                rst_n = 1'b0;
                #1;
                check("async_reset_if", {if_valid, if_instr, if_pc, if_pc_plus1}, '0);
                check("async_reset_req_halt", {imem_req, halted}, 2'b00);
                #2;
            end else begin
                #4;
                case (c)
                    0: check("c0_req", {imem_req, imem_addr, if_valid}, {1'b1, 32'h0, 1'b0});
                    1: check("c1_req", {imem_req, imem_addr}, {1'b1, 32'h1});
                    2: check("c2_if", {if_valid, if_pc, if_instr, imem_addr}, {1'b1, 32'h0, 32'h0500_0000, 32'h2});
                    3: check("c3_if", {if_pc, if_instr, imem_addr}, {32'h1, 32'h0D00_0001, 32'h3});
                    4: check("c4_if", {if_pc, if_pc_plus1}, {32'h2, 32'h3});
                    6, 7, 8: check("stall_skid", {imem_req, if_valid, if_pc}, {1'b0, 1'b1, 32'h4});
                    9: check("skid_drain_cycle", {imem_req, if_pc}, {1'b0, 32'h4});
                    10: check("skid_out", {if_valid, if_pc, imem_req, imem_addr}, {1'b1, 32'h5, 1'b1, 32'h6});
                    13: check("redir_flush", if_valid, 1'b0);
                    15: check("redir_issue", {imem_req, imem_addr}, {1'b1, 32'h40});
                    17: check("redir_first", {if_valid, if_pc}, {1'b1, 32'h40});
                    19: check("redir2_issue", {imem_req, imem_addr, if_valid}, {1'b1, 32'h8, 1'b0});
                    22: check("halt_deliver", {if_pc, if_opcode, halted, if_instr}, {32'h9, 5'h1F, 1'b1, 32'hFD00_0009});
                    43: check("unhalt", {halted, imem_req, imem_addr}, {1'b0, 1'b1, 32'h10});
                    46: check("flush_beats_stall", {if_valid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h20});
                    53: check("post_reset_req", {imem_req, imem_addr}, {1'b1, 32'h0});
                    54: check("post_reset_req2", {imem_req, imem_addr}, {1'b1, 32'h1});
                    55: check("post_reset_if", {if_valid, if_pc}, {1'b1, 32'h0});
                    default: ;
                endcase
                if (c >= 22 && c <= 41) check("halt_no_req", imem_req, 1'b0);
            end
        end

        // wrap-around start address on the second instance
        @(negedge clk);
        h_rst_n = 1'b1;
        #4;
        check("hi_first_req", {h_req, h_addr}, {1'b1, 32'hFFFF_FFFF});
        @(negedge clk);
        #4;
        check("hi_second_req", {h_req, h_addr}, {1'b1, 32'h0});
        @(negedge clk);
        #4;
        check("hi_first_if", {h_if_valid, h_if_pc, h_if_pc_plus1, h_if_instr},
              {1'b1, 32'hFFFF_FFFF, 32'h0, 32'h7DFF_FFFF});
        h_rst_n = 1'b0;
        #1;
        check("hi_async_reset", {h_if_valid, h_if_pc, h_req}, '0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
